// File: rtl/reg16_byte_reader.sv
// Streams a snapshotted register word onto an 8-bit bus as two valid/ready byte transfers.
// Optional macro READ_HI_FIRST_EN sends the high byte first; the default sends the low byte first.
module reg16_byte_reader #(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] q_in,
  input  logic              start,
  input  logic              rd_ready,
  output logic [BYTE_W-1:0] bus_out,
  output logic              bus_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND_FIRST,
    S_SEND_SECOND,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [BYTE_W-1:0] bus_out_q, bus_out_d;
  logic              bus_valid_q, bus_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [BYTE_W-1:0] first_byte, second_byte;
  logic              accept;

  // Byte order is taken from the next-cycle shadow so the first byte is ready on the capture edge.
`ifdef READ_HI_FIRST_EN
  assign first_byte  = shadow_d[DATA_W-1:BYTE_W];
  assign second_byte = shadow_d[BYTE_W-1:0];
`else
  assign first_byte  = shadow_d[BYTE_W-1:0];
  assign second_byte = shadow_d[DATA_W-1:BYTE_W];
`endif

  assign accept = bus_valid_q && rd_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = q_in;
          state_d  = S_SEND_FIRST;
        end
      end
      S_SEND_FIRST: begin
        if (accept) state_d = S_SEND_SECOND;
      end
      S_SEND_SECOND: begin
        if (accept) begin
          state_d = S_DONE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    bus_valid_d = (state_d == S_SEND_FIRST) || (state_d == S_SEND_SECOND);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    bus_out_d   = '0;
    if (state_d == S_SEND_FIRST)       bus_out_d = first_byte;
    else if (state_d == S_SEND_SECOND) bus_out_d = second_byte;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus_out    = bus_out_q;
  assign bus_valid  = bus_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_reg16_byte_reader.sv
// Self-checking bench for reg16_byte_reader: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level byte-queue model.
module tb_reg16_byte_reader;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] q_in = '0;
  logic        start = 1'b0;
  logic        rd_ready = 1'b0;
  logic [7:0]  bus_out;
  logic        bus_valid, busy, done;
  logic [7:0]  xfer_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bytes still owed to the bus, a pending done cycle and the word count.
  logic [7:0] m_pend[$];
  bit         m_done;
  int         m_count;

`ifdef READ_HI_FIRST_EN
  localparam bit HI_FIRST = 1'b1;
`else
  localparam bit HI_FIRST = 1'b0;
`endif

  reg16_byte_reader dut (
    .clk        (clk),
    .clr        (clr),
    .q_in       (q_in),
    .start      (start),
    .rd_ready   (rd_ready),
    .bus_out    (bus_out),
    .bus_valid  (bus_valid),
    .busy       (busy),
    .done       (done),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] first_of(input logic [15:0] w);
    return HI_FIRST ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_of(input logic [15:0] w);
    return HI_FIRST ? w[7:0] : w[15:8];
  endfunction

  task automatic mdl_reset();
    m_pend.delete();
    m_done  = 1'b0;
    m_count = 0;
  endtask

  // One clock edge worth of the word-read contract.
  task automatic mdl_edge();
    if (clr) begin
      mdl_reset();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_pend.size() == 0) begin
      if (start) begin
        m_pend.push_back(first_of(q_in));
        m_pend.push_back(second_of(q_in));
      end
    end else if (rd_ready) begin
      void'(m_pend.pop_front());
      if (m_pend.size() == 0) begin
        m_done  = 1'b1;
        m_count = (m_count + 1) % 256;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic       e_valid;
    logic [7:0] e_byte;
    e_valid = (m_pend.size() != 0);
    e_byte  = e_valid ? m_pend[0] : 8'h00;
    check({tag, ".valid"}, 32'(bus_valid), 32'(e_valid));
    check({tag, ".bus_out"}, 32'(bus_out), 32'(e_byte));
    check({tag, ".busy"}, 32'(busy), 32'(e_valid || m_done));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".count"}, 32'(xfer_count), 32'(m_count));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    mdl_edge();
    #1;
    compare_all(tag);
  endtask

  int done_seen;

  initial begin
    mdl_reset();

    // Reset then idle.
    #2;
    check("rst.valid", 32'(bus_valid), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.count", 32'(xfer_count), 0);
    #8 clr = 1'b0;
    for (int i = 0; i < 3; i++) step("idle");
    check("idle.bus_out", 32'(bus_out), 32'h00);

    // Basic read.
    q_in = 16'hA5C3; start = 1'b1; rd_ready = 1'b1;
    step("basic.c1");
    start = 1'b0; q_in = $urandom;
    check("basic.b0", 32'(bus_out), HI_FIRST ? 32'hA5 : 32'hC3);
    check("basic.v0", 32'(bus_valid), 1);
    step("basic.c2");
    check("basic.b1", 32'(bus_out), HI_FIRST ? 32'hC3 : 32'hA5);
    step("basic.c3");
    check("basic.done", 32'(done), 1);
    check("basic.count", 32'(xfer_count), 1);
    step("basic.c4");

    // Backpressure.
    q_in = 16'h1234; start = 1'b1; rd_ready = 1'b0;
    step("bp.cap");
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("bp.hold");
      check("bp.hold_byte", 32'(bus_out), HI_FIRST ? 32'h12 : 32'h34);
      check("bp.hold_valid", 32'(bus_valid), 1);
    end
    rd_ready = 1'b1;
    step("bp.c2");
    check("bp.b1", 32'(bus_out), HI_FIRST ? 32'h34 : 32'h12);
    step("bp.done");
    check("bp.done_pulse", 32'(done), 1);
    check("bp.count", 32'(xfer_count), 2);
    step("bp.idle");

    // Snapshot and ignored start.
    done_seen = 0;
    q_in = 16'hBEEF; start = 1'b1; rd_ready = 1'b1;
    step("snap.cap");
    check("snap.b0", 32'(bus_out), HI_FIRST ? 32'hBE : 32'hEF);
    q_in = 16'h0000;
    step("snap.c2");
    check("snap.b1", 32'(bus_out), HI_FIRST ? 32'hEF : 32'hBE);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("snap.tail");
      done_seen += int'(done);
    end
    check("snap.one_done", 32'(done_seen), 1);
    check("snap.count", 32'(xfer_count), 3);

    // Asynchronous reset while in SEND_SECOND.
    q_in = 16'hFFFF; start = 1'b1; rd_ready = 1'b1;
    step("clr.cap");
    start = 1'b0;
    step("clr.second");
    check("clr.pre_busy", 32'(busy), 1);
    #3 clr = 1'b1;
    #1;
    mdl_reset();
    check("clr.valid_now", 32'(bus_valid), 0);
    check("clr.busy_now", 32'(busy), 0);
    check("clr.count_now", 32'(xfer_count), 0);
    step("clr.held");
    clr = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step("clr.after");
      done_seen += int'(done);
    end
    check("clr.no_done", 32'(done_seen), 0);

    // Counter wrap: start held high, a done every 4 cycles starting at cycle 3.
    start = 1'b1; rd_ready = 1'b1;
    for (int cyc = 1; cyc <= 1024; cyc++) begin
      if (cyc % 4 == 0) q_in = $urandom;
      step("wrap");
      if (cyc == 1019) check("wrap.255", 32'(xfer_count), 255);
      if (cyc == 1023) check("wrap.0", 32'(xfer_count), 0);
    end
    start = 1'b0;
    step("wrap.end");

    // Random traffic.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      start    = ($urandom_range(0, 3) == 0);
      rd_ready = ($urandom_range(0, 3) != 0);
      q_in     = 16'($urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
